reg_file_32x32: RTL

- MIPS-style general-purpose register file: 32 registers x 32 bits, two asynchronous read ports, one synchronous write port.
- Sits directly downstream of the 5-bit write-destination selector (rt / rd / $31 choice). That selector's output drives waddr here.
- Read ports feed the ALU operand path; a third debug read port feeds the board display logic.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/reg_file_32x32.sv | 71 +++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types: register-file geometry and the
// architectural register numbers used by the write-destination selector and the register file.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_GP   = 5'd28;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_32x32.sv
// MIPS-style register file: 32 x 32 bits, two combinational operand read ports, a debug read port and one clocked write port.
// Optional macro REGFILE_WB_BYPASS_EN forwards the same-cycle write data to matching read ports.
module reg_file_32x32
  import cpu_pkg::*;
#(
  parameter int                      DATA_W   = cpu_pkg::DATA_W,
  parameter int                      ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [cpu_pkg::DATA_W-1:0] SP_RESET = 32'h0000_3FFC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
    // Entry 0 is kept at zero so every read port can index the array directly.
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET[DATA_W-1:0] : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic byp_valid;

  // byp_valid excludes waddr 0, so address 0 still reads as zero.
  assign byp_valid = we && (waddr != '0);
  assign rdata1    = (byp_valid && (raddr1   == waddr)) ? wdata : regs_q[raddr1];
  assign rdata2    = (byp_valid && (raddr2   == waddr)) ? wdata : regs_q[raddr2];
  assign dbg_data  = (byp_valid && (dbg_addr == waddr)) ? wdata : regs_q[dbg_addr];
`else
  assign rdata1    = regs_q[raddr1];
  assign rdata2    = regs_q[raddr2];
  assign dbg_data  = regs_q[dbg_addr];
`endif

`ifndef SYNTHESIS
  a_waddr_known: assert property (@(posedge clk) disable iff (!rst_n)
    we |-> !$isunknown(waddr))
    else $error("reg_file_32x32: write enabled with unknown waddr");

  a_wdata_known: assert property (@(posedge clk) disable iff (!rst_n)
    (we && (waddr != '0)) |-> !$isunknown(wdata))
    else $warning("reg_file_32x32: accepted write carries unknown wdata");
`endif

endmodule
